// File: rtl/vmul_pkg.sv
// Shared types for the vector multiply writeback buffer.
// Default widths and the multiplier latency live here.
package vmul_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int TAG_WIDTH  = 8;
    localparam int MUL_LAT    = 6;

    typedef logic [TAG_WIDTH-1:0] tag_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        tag_t                  tag;
    } wb_entry_t;

endpackage

// File: rtl/vmul_wb_fifo.sv
// Synchronous circular FIFO with occupancy count, sticky overflow
// flag and a show-ahead head that reads zero when empty.
module vmul_wb_fifo
    import vmul_pkg::*;
#(
    parameter int  DEPTH   = 8,
    parameter type entry_t = wb_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t push_entry,
    input  logic   pop_ready,
    output logic   head_valid,
    output entry_t head_entry,
    output logic   overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          pop;
    logic          wr_en;

    assign full       = (count == CW'(DEPTH));
    assign head_valid = (count != '0);
    assign pop        = head_valid & pop_ready;
    // A pop frees the head slot this cycle, so a full FIFO can still take a push.
    assign wr_en      = push & (~full | pop);
    assign head_entry = head_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push & full & ~pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/vmul_wb_buffer.sv
// Writeback buffer behind the fixed-latency vector multiplier: tag delay
// line, result FIFO and issue credits guaranteeing a slot per launched op.
module vmul_wb_buffer #(
    parameter int DATA_WIDTH = vmul_pkg::DATA_WIDTH,
    parameter int TAG_WIDTH  = vmul_pkg::TAG_WIDTH,
    parameter int DEPTH      = 8,
    parameter int MUL_LAT    = vmul_pkg::MUL_LAT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [TAG_WIDTH-1:0]  issue_tag,
    output logic                  issue_ready,
    input  logic                  mul_valid,
    input  logic [DATA_WIDTH-1:0] mul_vec,
    output logic                  wb_valid,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic [TAG_WIDTH-1:0]  wb_tag,
    input  logic                  wb_ready,
    output logic                  err_overflow,
    output logic                  err_misalign
);
    import vmul_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [TAG_WIDTH-1:0]  tag;
    } entry_t;

    logic [CW-1:0]        credits;
    logic                 acc;
    logic                 pop;
    logic [MUL_LAT-1:0]   pipe_v;
    logic [TAG_WIDTH-1:0] pipe_tag [MUL_LAT];
    entry_t               push_entry;
    entry_t               head_entry;

    assign issue_ready = (credits != '0);
    assign acc         = issue_valid & issue_ready;
    assign pop         = wb_valid & wb_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            credits <= CW'(DEPTH);
        end else if (acc & ~pop) begin
            credits <= credits - 1'b1;
        end else if (pop & ~acc) begin
            credits <= credits + 1'b1;
        end
    end

    // Delay line mirrors the multiplier so the last stage lines up with mul_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_v <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                pipe_tag[i] <= '0;
            end
        end else begin
            pipe_v      <= {pipe_v[MUL_LAT-2:0], acc};
            pipe_tag[0] <= issue_tag;
            for (int i = 1; i < MUL_LAT; i++) begin
                pipe_tag[i] <= pipe_tag[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_misalign <= 1'b0;
        end else if (mul_valid != pipe_v[MUL_LAT-1]) begin
            err_misalign <= 1'b1;
        end
    end

    assign push_entry = '{data: mul_vec, tag: pipe_tag[MUL_LAT-1]};

    vmul_wb_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (mul_valid),
        .push_entry (push_entry),
        .pop_ready  (wb_ready),
        .head_valid (wb_valid),
        .head_entry (head_entry),
        .overflow   (err_overflow)
    );

    assign wb_data = head_entry.data;
    assign wb_tag  = head_entry.tag;

endmodule
